// File: rtl/wb_master_arbiter_if.sv
// Signal bundle between the two CPU-side Wishbone masters, the arbiter and the shared slave bus.
// Handshake: a master raises mN_req_i with addr/data/we/sel valid and holds it until mN_ack_o pulses;
// the arbiter holds s_stb_o and all s_* fields stable until the slave answers with a one-cycle s_ack_i.
interface wb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic              m0_req_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic              m0_we_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_data_o;
  logic              m0_ack_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_we_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_data_o;
  logic              m1_ack_o;
  logic              m1_err_o;

  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o;
  logic              s_we_o;
  logic [SEL_W-1:0]  s_sel_o;
  logic              s_stb_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ack_i;

  logic [1:0]        grant_o;
  logic [1:0]        dbg_state;

  // master: the arbiter's view, since it is the one mastering the shared bus
  modport master (
    input  m0_req_i, m0_addr_i, m0_data_i, m0_we_i, m0_sel_i,
    output m0_data_o, m0_ack_o, m0_err_o,
    input  m1_req_i, m1_addr_i, m1_data_i, m1_we_i, m1_sel_i,
    output m1_data_o, m1_ack_o, m1_err_o,
    output s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o,
    input  s_data_i, s_ack_i,
    output grant_o, dbg_state
  );

  modport slave (
    output m0_req_i, m0_addr_i, m0_data_i, m0_we_i, m0_sel_i,
    input  m0_data_o, m0_ack_o, m0_err_o,
    output m1_req_i, m1_addr_i, m1_data_i, m1_we_i, m1_sel_i,
    input  m1_data_o, m1_ack_o, m1_err_o,
    input  s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o,
    output s_data_i, s_ack_i,
    input  grant_o, dbg_state
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with registered outputs and a watchdog that
// terminates unacknowledged transactions with an error completion.
module wb_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  wb_master_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              stb_q, stb_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      stb_q    <= 1'b0;
      grant_q  <= 2'b00;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      stb_q    <= stb_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // pick = 1 selects m1; on a tie round-robin hands the bus to whoever did not own it last
  always_comb begin
    if (RR_MODE != 0 && bus.m0_req_i && bus.m1_req_i) pick = ~last_q;
    else                                              pick = ~bus.m0_req_i;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        stb_d = 1'b0;
        we_d  = 1'b0;
        sel_d = '0;
        if (bus.m0_req_i || bus.m1_req_i) begin
          owner_d = pick;
          addr_d  = pick ? bus.m1_addr_i : bus.m0_addr_i;
          wdata_d = pick ? bus.m1_data_i : bus.m0_data_i;
          we_d    = pick ? bus.m1_we_i   : bus.m0_we_i;
          sel_d   = pick ? bus.m1_sel_i  : bus.m0_sel_i;
          stb_d   = 1'b1;
          grant_d = pick ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (bus.s_ack_i || cnt_q == CNT_LAST) begin
          // a real ack on the expiry cycle still counts as a clean completion
          if (owner_q) rdata1_d = bus.s_ack_i ? bus.s_data_i : '0;
          else         rdata0_d = bus.s_ack_i ? bus.s_data_i : '0;
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = ~bus.s_ack_i;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          state_d = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        ack_d   = 2'b00;
        err_d   = 2'b00;
        grant_d = 2'b00;
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.s_addr_o  = addr_q;
  assign bus.s_data_o  = wdata_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_sel_o   = sel_q;
  assign bus.s_stb_o   = stb_q;
  assign bus.grant_o   = grant_q;
  assign bus.m0_ack_o  = ack_q[0];
  assign bus.m1_ack_o  = ack_q[1];
  assign bus.m0_err_o  = err_q[0];
  assign bus.m1_err_o  = err_q[1];
  assign bus.m0_data_o = rdata0_q;
  assign bus.m1_data_o = rdata1_q;
  assign bus.dbg_state = state_q;

endmodule
